fetch_sequencer: RTL and testbench

//  Owns the architectural PC and sequences instruction fetch over a req/ack imem port.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose: owns the architectural PC, fetches over a req/ack imem port, presents one registered inst to decode.
// Latency: ack in cycle n -> inst_valid in cycle n+1; redirect in cycle n -> first target inst valid at n+2 or later.
// Backpressure: stall holds the presented inst; one extra fetched word parks in a hold buffer and fetch pauses.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    // FETCH keeps a request on the port; HOLD means the slot and the hold buffer are both full.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        consume;
    logic        slot_free;
    logic [31:0] target_pc;
    logic        unused_rpc_lsb;

    assign consume        = inst_valid_q & ~stall;
    assign slot_free      = ~inst_valid_q | consume;
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // While a squashed request is still in flight the port keeps showing its original
    // address, so the memory never sees the address change mid-request.
    assign imem_req   = (state_q == S_FETCH) & ~rst;
    assign imem_addr  = pend_q ? pend_addr_q : pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    // Next-state: redirect first, then the fetch/hold sequencing.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        hold_buf_d   = hold_buf_q;
        hold_pc_d    = hold_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        if (redirect_valid) begin
            inst_valid_d = 1'b0;
            state_d      = S_FETCH;
            pc_d         = target_pc;
            if (state_q == S_FETCH) begin
                if (imem_ack) begin
                    // Data arriving with the redirect is wrong-path; drop it.
                    pend_d = 1'b0;
                end else if (!pend_q) begin
                    // Outstanding request now belongs to the wrong path: squash its ack.
                    pend_d      = 1'b1;
                    pend_addr_d = pc_q;
                end
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack && pend_q) begin
                        pend_d = 1'b0;
                        if (consume) begin
                            inst_valid_d = 1'b0;
                        end
                    end else if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (slot_free) begin
                            inst_d       = imem_rdata;
                            inst_pc_d    = pc_q;
                            inst_valid_d = 1'b1;
                        end else begin
                            hold_buf_d = imem_rdata;
                            hold_pc_d  = pc_q;
                            state_d    = S_HOLD;
                        end
                    end else if (consume) begin
                        inst_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        inst_d       = hold_buf_q;
                        inst_pc_d    = hold_pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_addr_q  <= 32'd0;
            hold_buf_q   <= 32'd0;
            hold_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            hold_buf_q   <= hold_buf_d;
            hold_pc_q    <= hold_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: directed bench for fetch_sequencer with a scoreboard of expected (pc, inst) pairs.
// Latency: expectations are queued when the fetch is stimulated and popped when decode consumes.
// Backpressure: stall is driven by the stimulus; the monitor only pops on inst_valid & ~stall.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = word_at(pc);
        sb_q.push_back(e);
    endtask

    // One clock cycle: drive inputs just after the edge, return at the following negedge.
    task automatic cyc(input logic r, input logic st, input logic ak,
                       input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst            = r;
        stall          = st;
        imem_ack       = ak;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    // Monitor: every instruction decode consumes must be the next expected one.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_inst actual_pc=%h actual_inst=%h expected=none", inst_pc, inst);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_inst_pc", inst_pc, e.pc);
                check("sb_inst", inst, e.ins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 32'd0);
        cyc(1, 0, 0, 0, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_3000);

        // 1: zero-wait memory, one instruction per cycle
        expect_inst(32'h0000_3000);
        expect_inst(32'h0000_3004);
        expect_inst(32'h0000_3008);
        expect_inst(32'h0000_300C);
        cyc(0, 0, 1, 0, 32'd0);
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 32'd0);
            check("t1_valid", {31'd0, inst_valid}, 32'd1);
        end
        cyc(0, 0, 0, 0, 32'd0);
        check("t1_valid_last", {31'd0, inst_valid}, 32'd1);

        // 2: stall with a fetch in flight -> hold buffer
        expect_inst(32'h0000_3010);
        expect_inst(32'h0000_3014);
        cyc(0, 0, 1, 0, 32'd0);
        check("t2_empty", {31'd0, inst_valid}, 32'd0);
        check("t2_addr0", imem_addr, 32'h0000_3010);
        cyc(0, 1, 1, 0, 32'd0);
        check("t2_addr1", imem_addr, 32'h0000_3014);
        cyc(0, 1, 0, 0, 32'd0);
        check("t2_hold_req", {31'd0, imem_req}, 32'd0);
        check("t2_hold_pc", inst_pc, 32'h0000_3010);
        cyc(0, 1, 0, 0, 32'd0);
        check("t2_hold_req2", {31'd0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        check("t2_hold_req3", {31'd0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        check("t2_held_pc", inst_pc, 32'h0000_3014);
        check("t2_resume_req", {31'd0, imem_req}, 32'd1);
        check("t2_resume_addr", imem_addr, 32'h0000_3018);

        // 3: redirect while an ack is outstanding -> that ack is squashed
        expect_inst(32'h0000_3100);
        cyc(0, 0, 0, 0, 32'd0);
        check("t3_addr0", imem_addr, 32'h0000_3018);
        cyc(0, 0, 0, 1, 32'h0000_3100);
        cyc(0, 0, 0, 0, 32'd0);
        check("t3_req_pend", {31'd0, imem_req}, 32'd1);
        check("t3_addr_pend", imem_addr, 32'h0000_3018);
        check("t3_valid_pend", {31'd0, inst_valid}, 32'd0);
        cyc(0, 0, 1, 0, 32'd0);
        check("t3_addr_ack", imem_addr, 32'h0000_3018);
        cyc(0, 0, 1, 0, 32'd0);
        check("t3_addr_target", imem_addr, 32'h0000_3100);
        check("t3_valid_squash", {31'd0, inst_valid}, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        check("t3_valid_target", {31'd0, inst_valid}, 32'd1);

        // 4: redirect coincident with ack and stall, unaligned target
        cyc(0, 0, 1, 0, 32'd0);
        check("t4_addr0", imem_addr, 32'h0000_3104);
        cyc(0, 1, 1, 1, 32'h0000_3102);
        check("t4_valid_before", {31'd0, inst_valid}, 32'd1);
        expect_inst(32'h0000_3100);
        cyc(0, 0, 0, 0, 32'd0);
        check("t4_valid_dropped", {31'd0, inst_valid}, 32'd0);
        check("t4_addr_target", imem_addr, 32'h0000_3100);
        check("t4_req", {31'd0, imem_req}, 32'd1);
        cyc(0, 0, 1, 0, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);

        // 5: PC wraps from the top of the address space
        expect_inst(32'hFFFF_FFFC);
        cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 0, 32'd0);
        check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("t5_valid", {31'd0, inst_valid}, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        check("t5_addr_wrap", imem_addr, 32'h0000_0000);

        // 6: reset in the middle of a request
        cyc(0, 0, 1, 0, 32'd0);
        cyc(0, 1, 0, 0, 32'd0);
        check("t6_valid_pre", {31'd0, inst_valid}, 32'd1);
        check("t6_addr_pre", imem_addr, 32'h0000_0004);
        cyc(1, 1, 0, 0, 32'd0);
        check("t6_req_in_rst", {31'd0, imem_req}, 32'd0);
        cyc(1, 0, 1, 0, 32'd0);
        check("t6_req_in_rst2", {31'd0, imem_req}, 32'd0);
        check("t6_valid_rst", {31'd0, inst_valid}, 32'd0);
        check("t6_inst_rst", inst, 32'd0);
        check("t6_inst_pc_rst", inst_pc, 32'd0);
        check("t6_addr_rst", imem_addr, 32'h0000_3000);
        expect_inst(32'h0000_3000);
        cyc(0, 0, 0, 0, 32'd0);
        check("t6_req_after", {31'd0, imem_req}, 32'd1);
        check("t6_addr_after", imem_addr, 32'h0000_3000);
        check("t6_valid_after", {31'd0, inst_valid}, 32'd0);
        cyc(0, 0, 1, 0, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);
        cyc(0, 0, 0, 0, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
